// File: rtl/rhythm_hit_judge.sv
// rhythm_hit_judge: grades each note as PERFECT / GOOD / MISS from the cycle
// distance between the note-arrival pulse and the debounced push pulse. It also
// keeps a saturating score, combo and max combo for the display stage.
// Optional feature macro: STRAY_PENALTY_EN. When defined, a push with no open
// note counts as a MISS.
module rhythm_hit_judge #(
    parameter int PERFECT_WIN = 1_000_000,
    parameter int GOOD_WIN    = 5_000_000,
    parameter int CNT_W       = 23,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 10,
    parameter int PERFECT_PTS = 2,
    parameter int GOOD_PTS    = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_fPush,
    input  logic               i_fNote,
    output logic               o_fPerfect,
    output logic               o_fGood,
    output logic               o_fMiss,
    output logic [1:0]         o_Judge,
    output logic [SCORE_W-1:0] o_Score,
    output logic [COMBO_W-1:0] o_Combo,
    output logic [COMBO_W-1:0] o_MaxCombo
);

    typedef enum logic {S_IDLE = 1'b0, S_OPEN = 1'b1} state_t;

    localparam logic [CNT_W-1:0]   PERFECT_LIM = CNT_W'(PERFECT_WIN);
    localparam logic [CNT_W-1:0]   EXPIRE_CNT  = CNT_W'(GOOD_WIN - 1);
    localparam logic [SCORE_W-1:0] PERFECT_ADD = SCORE_W'(PERFECT_PTS);
    localparam logic [SCORE_W-1:0] GOOD_ADD    = SCORE_W'(GOOD_PTS);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_p0, cnt_nxt;

    logic               perfect_p0, good_p0, miss_p0, stray_p0;
    logic [COMBO_W-1:0] combo_inc_p0;
    logic [COMBO_W-1:0] max_inc_p0;

    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0] s,
        input logic [SCORE_W-1:0] pts
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {1'b0, pts};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] c);
        return (c == {COMBO_W{1'b1}}) ? c : c + COMBO_W'(1);
    endfunction

    // State register: window state and distance counter.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state  <= S_IDLE;
            cnt_p0 <= '0;
        end else begin
            state  <= state_nxt;
            cnt_p0 <= cnt_nxt;
        end
    end

    // Next state: a new note always restarts the window; a push or expiry closes it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_p0;
        case (state)
            S_IDLE: begin
                if (i_fNote && !i_fPush) begin
                    state_nxt = S_OPEN;
                    cnt_nxt   = '0;
                end
            end
            S_OPEN: begin
                if (i_fNote) begin
                    cnt_nxt = '0;
                end else if (i_fPush || cnt_p0 == EXPIRE_CNT) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p0 + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Judgement decode for the current cycle. A push in the expiry cycle still
    // counts as GOOD because the counter has not yet reached GOOD_WIN.
    always_comb begin
        perfect_p0 = 1'b0;
        good_p0    = 1'b0;
        miss_p0    = 1'b0;
        stray_p0   = 1'b0;
        if (state == S_OPEN) begin
            perfect_p0 = i_fPush && (cnt_p0 < PERFECT_LIM);
            good_p0    = i_fPush && (cnt_p0 >= PERFECT_LIM);
            miss_p0    = !i_fPush && (i_fNote || cnt_p0 == EXPIRE_CNT);
        end else begin
            perfect_p0 = i_fPush && i_fNote;
`ifdef STRAY_PENALTY_EN
            stray_p0   = i_fPush && !i_fNote;
`else
            stray_p0   = 1'b0;
`endif
        end
        combo_inc_p0 = sat_inc_combo(o_Combo);
        max_inc_p0   = (combo_inc_p0 > o_MaxCombo) ? combo_inc_p0 : o_MaxCombo;
    end

    // ---- stage p0 -> p1: registered judgement pulses and scoreboard ----
    // Output register: one-cycle pulses plus score / combo bookkeeping.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_fPerfect <= 1'b0;
            o_fGood    <= 1'b0;
            o_fMiss    <= 1'b0;
            o_Judge    <= 2'd0;
            o_Score    <= '0;
            o_Combo    <= '0;
            o_MaxCombo <= '0;
        end else begin
            o_fPerfect <= perfect_p0;
            o_fGood    <= good_p0;
            o_fMiss    <= miss_p0 || stray_p0;
            if (perfect_p0) begin
                o_Judge    <= 2'd1;
                o_Score    <= sat_add_score(o_Score, PERFECT_ADD);
                o_Combo    <= combo_inc_p0;
                o_MaxCombo <= max_inc_p0;
            end else if (good_p0) begin
                o_Judge    <= 2'd2;
                o_Score    <= sat_add_score(o_Score, GOOD_ADD);
                o_Combo    <= combo_inc_p0;
                o_MaxCombo <= max_inc_p0;
            end else if (miss_p0 || stray_p0) begin
                o_Judge <= 2'd3;
                o_Combo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rhythm_hit_judge.sv
// Directed bench for rhythm_hit_judge with small windows (PERFECT_WIN=4,
// GOOD_WIN=10), a 4-bit score and a 3-bit combo, so that saturation is reachable.
module tb_rhythm_hit_judge;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       note;
    logic       f_perfect, f_good, f_miss;
    logic [1:0] judge;
    logic [3:0] score;
    logic [2:0] combo, max_combo;
    logic [2:0] flags;

    int n_chk  = 0;
    int n_pass = 0;

    assign flags = {f_perfect, f_good, f_miss};

    always #5 clk = ~clk;

    rhythm_hit_judge #(
        .PERFECT_WIN(4),
        .GOOD_WIN   (10),
        .CNT_W      (4),
        .SCORE_W    (4),
        .COMBO_W    (3),
        .PERFECT_PTS(2),
        .GOOD_PTS   (1)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_fPush   (push),
        .i_fNote   (note),
        .o_fPerfect(f_perfect),
        .o_fGood   (f_good),
        .o_fMiss   (f_miss),
        .o_Judge   (judge),
        .o_Score   (score),
        .o_Combo   (combo),
        .o_MaxCombo(max_combo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic n, input logic p);
        note = n;
        push = p;
        tick();
        note = 1'b0;
        push = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    initial begin
        logic [2:0] seen;
        int         nperf;

        rst  = 1'b1;
        note = 1'b0;
        push = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", flags, 0);
        check("reset_judge", judge, 0);
        check("reset_score", score, 0);
        check("reset_combo", combo, 0);
        check("reset_max", max_combo, 0);
        rst = 1'b0;
        tick();

        // PERFECT: push two cycles after the note
        drive(1, 0);
        check("t1_no_early", flags, 0);
        drive(0, 0);
        drive(0, 1);
        check("t1_flags", flags, 3'b100);
        check("t1_judge", judge, 1);
        check("t1_score", score, 2);
        check("t1_combo", combo, 1);
        check("t1_max", max_combo, 1);
        tick();
        check("t1_pulse_1clk", flags, 0);
        check("t1_judge_hold", judge, 1);

        // GOOD: push seven cycles after the note
        drive(1, 0);
        idle(6);
        drive(0, 1);
        check("t2_flags", flags, 3'b010);
        check("t2_judge", judge, 2);
        check("t2_score", score, 3);
        check("t2_combo", combo, 2);

        // last PERFECT cycle (counter 3) and first GOOD cycle (counter 4)
        drive(1, 0);
        idle(3);
        drive(0, 1);
        check("edge_perfect", flags, 3'b100);
        check("edge_perfect_score", score, 5);
        drive(1, 0);
        idle(4);
        drive(0, 1);
        check("edge_good", flags, 3'b010);
        check("edge_good_score", score, 6);
        check("edge_good_max", max_combo, 4);

        // push in the expiry cycle (counter 9) is still GOOD
        drive(1, 0);
        idle(9);
        drive(0, 1);
        check("last_good", flags, 3'b010);
        check("last_good_score", score, 7);
        check("last_good_combo", combo, 5);

        // timeout: MISS only on the tenth cycle after the note
        drive(1, 0);
        seen = 3'b000;
        for (int k = 1; k < 10; k++) begin
            tick();
            seen = seen | flags;
        end
        check("t2_miss_early", seen, 0);
        tick();
        check("t2_miss_flags", flags, 3'b001);
        check("t2_miss_judge", judge, 3);
        check("t2_miss_combo", combo, 0);
        check("t2_miss_max", max_combo, 5);
        check("t2_miss_score", score, 7);

        // note and push together from idle
        drive(1, 1);
        check("t3_same_flags", flags, 3'b100);
        check("t3_same_score", score, 9);
        check("t3_same_combo", combo, 1);

        // second note without push misses the first, then times out itself
        drive(1, 0);
        idle(2);
        drive(1, 0);
        check("t3_renote_miss", flags, 3'b001);
        check("t3_renote_combo", combo, 0);
        seen = 3'b000;
        for (int k = 1; k < 10; k++) begin
            tick();
            seen = seen | flags;
        end
        check("t3_second_early", seen, 0);
        tick();
        check("t3_second_miss", flags, 3'b001);

        // note + push while open: push judges the old note, the new window restarts
        drive(1, 0);
        idle(2);
        drive(1, 1);
        check("open_notepush", flags, 3'b100);
        check("open_notepush_score", score, 11);
        drive(0, 1);
        check("restart_perfect", flags, 3'b100);
        check("restart_score", score, 13);
        check("restart_combo", combo, 2);

        // eight back-to-back PERFECTs: score and combo saturate
        nperf = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1);
            if (f_perfect) nperf++;
            if (i == 0) check("sat_score_15", score, 15);
            if (i == 1) check("sat_score_clamp", score, 15);
        end
        check("sat_nperf", nperf, 8);
        check("sat_score", score, 15);
        check("sat_combo", combo, 7);
        check("sat_max", max_combo, 7);

        // stray push in idle
        drive(0, 1);
`ifdef STRAY_PENALTY_EN
        check("stray_flags", flags, 3'b001);
        check("stray_combo", combo, 0);
        check("stray_judge", judge, 3);
`else
        check("stray_flags", flags, 0);
        check("stray_combo", combo, 7);
        check("stray_judge", judge, 1);
`endif
        check("stray_max", max_combo, 7);

        // reset five cycles into a window
        drive(1, 0);
        idle(4);
        rst = 1'b1;
        #1;
        check("rst_flags", flags, 0);
        check("rst_judge", judge, 0);
        check("rst_score", score, 0);
        check("rst_combo", combo, 0);
        check("rst_max", max_combo, 0);
        tick();
        tick();
        rst = 1'b0;
        seen = 3'b000;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen = seen | flags;
        end
        check("rst_no_miss", seen, 0);
        drive(1, 0);
        drive(0, 0);
        drive(0, 1);
        check("post_rst_flags", flags, 3'b100);
        check("post_rst_score", score, 2);
        check("post_rst_combo", combo, 1);
        check("post_rst_judge", judge, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
